// File: rtl/alu_status_unit_if.sv
// ALU status / exception bundle between the ALU commit stage, the status unit
// and the CPU controller.
interface alu_status_unit_if #(
  parameter int COUNT_W = 8
);
  logic               status_valid;
  logic [7:0]         status_in;
  logic [3:0]         alu_control;
  logic               mem_access;
  logic [31:0]        pc_in;
  logic               exc_ack;
  logic               clear_sticky;
  logic [7:0]         flags_q;
  logic [7:0]         sticky;
  logic               exc_req;
  logic [3:0]         exc_cause;
  logic [31:0]        epc;
  logic               exc_missed;
  logic [COUNT_W-1:0] exc_count;

  modport master (
    output status_valid, status_in, alu_control, mem_access, pc_in,
           exc_ack, clear_sticky,
    input  flags_q, sticky, exc_req, exc_cause, epc, exc_missed, exc_count
  );

  modport slave (
    input  status_valid, status_in, alu_control, mem_access, pc_in,
           exc_ack, clear_sticky,
    output flags_q, sticky, exc_req, exc_cause, epc, exc_missed, exc_count
  );
endinterface

// File: rtl/alu_status_unit.sv
// Registers ALU flags, accumulates sticky flags and raises a held exception
// request (cause + EPC) to the controller until it is acknowledged.
//
//   state   | meaning
//   IDLE    | no exception outstanding
//   PENDING | exc_req held, cause/epc frozen until exc_ack
module alu_status_unit #(
  parameter logic [3:0] EXC_MASK = 4'b1111,
  parameter int         COUNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst,
  alu_status_unit_if.slave    bus
);

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam logic [3:0] CTL_ADD = 4'd2;
  localparam logic [3:0] CTL_SUB = 4'd6;
  localparam logic [3:0] CTL_MUL = 4'd5;
  localparam logic [3:0] CTL_DIV = 4'd4;

  state_t             r_state;
  logic [7:0]         r_flags;
  logic [7:0]         r_sticky;
  logic               r_exc_req;
  logic [3:0]         r_exc_cause;
  logic [31:0]        r_epc;
  logic               r_exc_missed;
  logic [COUNT_W-1:0] r_exc_count;

  logic       w_div0;
  logic       w_mis;
  logic       w_movf;
  logic       w_carry;
  logic       w_event;
  logic [3:0] w_cause;

  always_comb begin
    w_div0  = bus.status_valid & bus.status_in[2] & (bus.alu_control == CTL_DIV)
              & EXC_MASK[0];
    w_mis   = bus.status_valid & bus.status_in[3] & (bus.alu_control == CTL_ADD)
              & bus.mem_access & EXC_MASK[1];
    w_movf  = bus.status_valid & bus.status_in[6] & (bus.alu_control == CTL_MUL)
              & EXC_MASK[2];
    w_carry = bus.status_valid & bus.status_in[5]
              & ((bus.alu_control == CTL_ADD) | (bus.alu_control == CTL_SUB))
              & ~bus.mem_access & EXC_MASK[3];
    w_event = w_div0 | w_mis | w_movf | w_carry;
    w_cause = 4'd0;
    if (w_div0)       w_cause = 4'd1;
    else if (w_mis)   w_cause = 4'd2;
    else if (w_movf)  w_cause = 4'd3;
    else if (w_carry) w_cause = 4'd4;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_flags      <= 8'h00;
      r_sticky     <= 8'h00;
      r_exc_req    <= 1'b0;
      r_exc_cause  <= 4'd0;
      r_epc        <= 32'h0;
      r_exc_missed <= 1'b0;
      r_exc_count  <= '0;
    end else begin
      if (bus.status_valid) begin
        r_flags  <= bus.status_in;
        r_sticky <= (bus.clear_sticky ? 8'h00 : r_sticky) | bus.status_in;
      end else if (bus.clear_sticky) begin
        r_sticky <= 8'h00;
      end

      case (r_state)
        IDLE: begin
          if (w_event) begin
            r_state     <= PENDING;
            r_exc_req   <= 1'b1;
            r_exc_cause <= w_cause;
            r_epc       <= bus.pc_in;
            if (r_exc_count != '1) r_exc_count <= r_exc_count + COUNT_W'(1);
          end
        end
        PENDING: begin
          if (bus.exc_ack) begin
            // an event in the ack cycle is taken back-to-back
            if (w_event) begin
              r_exc_cause <= w_cause;
              r_epc       <= bus.pc_in;
              if (r_exc_count != '1) r_exc_count <= r_exc_count + COUNT_W'(1);
            end else begin
              r_state     <= IDLE;
              r_exc_req   <= 1'b0;
              r_exc_cause <= 4'd0;
            end
          end else if (w_event) begin
            r_exc_missed <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.flags_q    = r_flags;
  assign bus.sticky     = r_sticky;
  assign bus.exc_req    = r_exc_req;
  assign bus.exc_cause  = r_exc_cause;
  assign bus.epc        = r_epc;
  assign bus.exc_missed = r_exc_missed;
  assign bus.exc_count  = r_exc_count;

endmodule

// File: tb/tb_alu_status_unit.sv
// Directed-vector bench for alu_status_unit: default mask instance plus a
// second instance with the carry cause masked off.
module tb_alu_status_unit;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  alu_status_unit_if #(.COUNT_W(8)) ifa ();
  alu_status_unit_if #(.COUNT_W(8)) ifb ();

  alu_status_unit #(.EXC_MASK(4'b1111), .COUNT_W(8)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  alu_status_unit #(.EXC_MASK(4'b0111), .COUNT_W(8)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op_a(input logic [3:0] ctl, input logic [7:0] st,
                      input logic mem, input logic [31:0] pc, input logic ack);
    ifa.status_valid = 1'b1;
    ifa.alu_control  = ctl;
    ifa.status_in    = st;
    ifa.mem_access   = mem;
    ifa.pc_in        = pc;
    ifa.exc_ack      = ack;
    step();
    ifa.status_valid = 1'b0;
    ifa.exc_ack      = 1'b0;
    ifa.mem_access   = 1'b0;
  endtask

  task automatic ack_a();
    ifa.exc_ack = 1'b1;
    step();
    ifa.exc_ack = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    ifa.status_valid = 0; ifa.status_in = 0; ifa.alu_control = 0; ifa.mem_access = 0;
    ifa.pc_in = 0; ifa.exc_ack = 0; ifa.clear_sticky = 0;
    ifb.status_valid = 0; ifb.status_in = 0; ifb.alu_control = 0; ifb.mem_access = 0;
    ifb.pc_in = 0; ifb.exc_ack = 0; ifb.clear_sticky = 0;
    step();
    step();
    rst = 1'b0;

    chk("rst_flags",  ifa.flags_q,    0);
    chk("rst_sticky", ifa.sticky,     0);
    chk("rst_req",    ifa.exc_req,    0);
    chk("rst_cause",  ifa.exc_cause,  0);
    chk("rst_epc",    ifa.epc,        0);
    chk("rst_missed", ifa.exc_missed, 0);
    chk("rst_count",  ifa.exc_count,  0);

    // divide by zero
    op_a(4'd4, 8'h84, 1'b0, 32'h0040_0010, 1'b0);
    chk("div0_req",   ifa.exc_req,   1);
    chk("div0_cause", ifa.exc_cause, 1);
    chk("div0_epc",   ifa.epc,       32'h0040_0010);
    chk("div0_count", ifa.exc_count, 1);
    chk("div0_flags", ifa.flags_q,   8'h84);
    ack_a();
    chk("ack1_req", ifa.exc_req, 0);

    // misaligned wins, carry suppressed by mem_access
    op_a(4'd2, 8'h28, 1'b1, 32'h0000_0020, 1'b0);
    chk("mis_cause", ifa.exc_cause, 2);
    chk("mis_count", ifa.exc_count, 2);
    ack_a();
    chk("ack2_req",   ifa.exc_req,   0);
    chk("ack2_cause", ifa.exc_cause, 0);
    chk("ack2_epc",   ifa.epc,       32'h0000_0020);

    // ack while idle is ignored
    ack_a();
    chk("idle_ack_req",   ifa.exc_req,   0);
    chk("idle_ack_count", ifa.exc_count, 2);

    // missed event while pending, then back-to-back on ack
    op_a(4'd4, 8'h04, 1'b0, 32'h0000_0030, 1'b0);
    chk("pend_missed0", ifa.exc_missed, 0);
    op_a(4'd5, 8'h40, 1'b0, 32'h0000_0040, 1'b0);
    chk("miss_cause",  ifa.exc_cause,  1);
    chk("miss_epc",    ifa.epc,        32'h0000_0030);
    chk("miss_flag",   ifa.exc_missed, 1);
    chk("miss_flags",  ifa.flags_q,    8'h40);
    chk("miss_count",  ifa.exc_count,  3);
    op_a(4'd5, 8'h40, 1'b0, 32'h0000_0044, 1'b1);
    chk("b2b_req",   ifa.exc_req,   1);
    chk("b2b_cause", ifa.exc_cause, 3);
    chk("b2b_epc",   ifa.epc,       32'h0000_0044);
    chk("b2b_count", ifa.exc_count, 4);
    ack_a();
    chk("ack3_req", ifa.exc_req, 0);

    // mul overflow bit under add: no exception, sticky only
    op_a(4'd2, 8'h40, 1'b0, 32'h0000_0050, 1'b0);
    chk("ovf_add_req", ifa.exc_req,   0);
    chk("ovf_add_st6", ifa.sticky[6], 1);
    ifa.clear_sticky = 1'b1;
    op_a(4'd0, 8'h80, 1'b0, 32'h0000_0054, 1'b0);
    ifa.clear_sticky = 1'b0;
    chk("clr_valid_sticky", ifa.sticky,  8'h80);
    chk("clr_valid_flags",  ifa.flags_q, 8'h80);
    ifa.clear_sticky = 1'b1;
    step();
    ifa.clear_sticky = 1'b0;
    chk("clr_only_sticky", ifa.sticky,  8'h00);
    chk("clr_only_flags",  ifa.flags_q, 8'h80);

    // sub carry-out on the fully enabled instance
    op_a(4'd6, 8'h20, 1'b0, 32'h0000_0060, 1'b0);
    chk("carry_cause", ifa.exc_cause, 4);
    chk("carry_epc",   ifa.epc,       32'h0000_0060);
    ack_a();

    // reset while pending
    op_a(4'd4, 8'h04, 1'b0, 32'h0000_0070, 1'b0);
    chk("pre_rst_req", ifa.exc_req, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("prst_req",    ifa.exc_req,    0);
    chk("prst_cause",  ifa.exc_cause,  0);
    chk("prst_epc",    ifa.epc,        0);
    chk("prst_missed", ifa.exc_missed, 0);
    chk("prst_count",  ifa.exc_count,  0);
    chk("prst_flags",  ifa.flags_q,    0);
    chk("prst_sticky", ifa.sticky,     0);
    ack_a();
    chk("prst_ack_req",   ifa.exc_req,   0);
    chk("prst_ack_cause", ifa.exc_cause, 0);

    // masked carry on instance B
    ifb.status_valid = 1'b1;
    ifb.alu_control  = 4'd6;
    ifb.status_in    = 8'h20;
    ifb.pc_in        = 32'h0000_0100;
    step();
    ifb.status_valid = 1'b0;
    chk("mask_req",   ifb.exc_req,   0);
    chk("mask_count", ifb.exc_count, 0);
    chk("mask_flags", ifb.flags_q,   8'h20);

    // 300 div0 events, each acknowledged back-to-back: count saturates
    ifb.alu_control  = 4'd4;
    ifb.status_in    = 8'h04;
    ifb.status_valid = 1'b1;
    ifb.exc_ack      = 1'b1;
    for (int i = 0; i < 300; i++) begin
      ifb.pc_in = 32'h0000_1000 + 32'(i);
      step();
      if (i == 9) chk("sat_count_10", ifb.exc_count, 10);
    end
    ifb.status_valid = 1'b0;
    ifb.exc_ack      = 1'b0;
    chk("sat_count", ifb.exc_count, 8'hFF);
    chk("sat_req",   ifb.exc_req,   1);
    chk("sat_epc",   ifb.epc,       32'h0000_1000 + 32'd299);
    chk("sat_missed", ifb.exc_missed, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_status_unit.md
Name: alu_status_unit

Overview:
- Consumes the 8-bit ALU status vector and the 4-bit ALU control code for each committed ALU operation.
- Registers the last flags and accumulates sticky flags.
- Detects exceptional conditions (divide-by-zero, misaligned word address, multiply overflow, add/sub carry-out) and raises a held exception request with cause and EPC to the CPU controller until acknowledged.
- Sits between the ALU and the control/exception logic.

Parameters:
- EXC_MASK, 4'b1111, per-cause enable: bit0 div0, bit1 misaligned, bit2 mul overflow, bit3 add/sub carry.
- COUNT_W, 8, width of the saturating taken-exception counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- status_valid  input  1  ALU op commits this cycle; status_in, alu_control, mem_access and pc_in are valid.
- status_in  input  8  ALU status: [7] zero, [6] mul overflow, [5] add/sub carry, [4] negative, [3] word misaligned, [2] div by zero, [1:0] always 0.
- alu_control  input  4  ALU control code of the committed op: 2 add, 6 sub, 5 mul, 4 div.
- mem_access  input  1  op is a load/store address computation.
- pc_in  input  32  PC of the committed instruction.
- exc_ack  input  1  controller accepts the pending exception.
- clear_sticky  input  1  clear sticky flags.
- flags_q  output  8  status of the last committed op.
- sticky  output  8  OR of status since reset or last clear.
- exc_req  output  1  exception pending; held until acknowledged.
- exc_cause  output  4  1 div0, 2 misaligned, 3 mul overflow, 4 add/sub carry, 0 none.
- epc  output  32  pc_in of the faulting op.
- exc_missed  output  1  sticky: an exception event occurred while one was pending and was not recorded.
- exc_count  output  COUNT_W  number of taken exceptions, saturating.

Behaviour:
- All state updates on the rising edge of clk.
- rst=1: flags_q=0, sticky=0, exc_req=0, exc_cause=0, epc=0, exc_missed=0, exc_count=0, FSM=IDLE. rst overrides all other inputs, including mid-PENDING.
- Flag capture, on status_valid=1:
  - flags_q <= status_in.
  - sticky <= (clear_sticky ? 0 : sticky) | status_in.
  - With status_valid=0 and clear_sticky=1: sticky <= 0.
  - Inputs are registered as given; bits [1:0] are not forced.
- Event detection is combinational on status_valid=1. Qualifiers:
  - div0 = status_in[2] & alu_control==4 & EXC_MASK[0]
  - mis = status_in[3] & alu_control==2 & mem_access & EXC_MASK[1]
  - movf = status_in[6] & alu_control==5 & EXC_MASK[2]
  - carry = status_in[5] & (alu_control==2 | alu_control==6) & ~mem_access & EXC_MASK[3]
- Priority for the cause: div0 > mis > movf > carry. A status bit set under a non-matching control code is ignored for exceptions but still recorded in flags_q and sticky.
- FSM:
  - IDLE: on an event, go to PENDING and latch exc_cause and epc=pc_in. exc_count increments, saturating at all-ones. exc_req=1 from the next cycle, i.e. 1-cycle latency.
  - IDLE, exc_ack=1: ignored.
  - PENDING: exc_req=1; exc_cause and epc stay stable.
  - PENDING, exc_ack=1 with no event: go to IDLE, exc_req=0 and exc_cause=0 next cycle; epc holds its value.
  - PENDING, exc_ack=1 with an event in the same cycle: stay PENDING, latch the new cause and epc, exc_count increments. This is a back-to-back exception.
  - PENDING, event without exc_ack: event not latched, exc_missed <= 1. flags_q and sticky still update.
- exc_missed clears only on rst.

Test Plan:
- Reset, then status_valid with alu_control=4, status_in=8'h84, pc_in=32'h0040_0010 -> next cycle exc_req=1, exc_cause=1, epc=32'h0040_0010, exc_count=1, flags_q=8'h84.
- alu_control=2, mem_access=1, status_in=8'h28 (carry + misaligned) -> exc_cause=2 (carry suppressed because mem_access=1). Then exc_ack -> exc_req=0 and exc_cause=0 the following cycle, epc held.
- While PENDING, present mul overflow (alu_control=5, status_in=8'h40) without ack -> cause unchanged, exc_missed=1, flags_q=8'h40. Repeat with exc_ack=1 in the same cycle -> exc_cause=3 with the new epc, exc_req stays 1.
- status_in=8'h40 with alu_control=2 -> no exception; sticky[6]=1. Then assert clear_sticky together with status_valid, status_in=8'h80 -> sticky=8'h80.
- EXC_MASK=4'b0111: sub with status_in=8'h20 -> no exc_req. Then 300 div0 events, each acknowledged -> exc_count saturates at 8'hFF.
- Assert rst while PENDING -> all outputs 0 the next cycle; a subsequent exc_ack has no effect.
